// File: rtl/score_scan_ctrl_pkg.sv
// Shared definitions for the score display controller: FSM states,
// digit slot indices, the dash code and BCD sizing helper.
package score_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] DIG_R_ONES = 2'd0;
  localparam logic [1:0] DIG_R_TENS = 2'd1;
  localparam logic [1:0] DIG_L_ONES = 2'd2;
  localparam logic [1:0] DIG_L_TENS = 2'd3;

  localparam logic [3:0] DIGIT_DASH = 4'hF;

  // Number of BCD nibbles needed to hold a w-bit binary value. At least
  // three so that anything above 99 shows up in the hundreds nibble.
  function automatic int unsigned bcd_digits(input int unsigned w);
    int unsigned n;
    n = (w + 2) / 3;
    if (n < 3) n = 3;
    return n;
  endfunction

endpackage

// File: rtl/score_scan_ctrl_bin2bcd.sv
// Single-score sequential double-dabble. i_start latches the binary value
// and clears the BCD accumulator; one shift-and-adjust iteration follows
// per clock until SCORE_W iterations are done. o_done is high during the
// cycle whose closing edge performs the final iteration.
module bin2bcd_seq
  import score_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic [7:0]         o_bcd2,
  output logic               o_ovf,
  output logic               o_done
);

  localparam int unsigned ND = bcd_digits(SCORE_W);
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned CW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] r_bin;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_lost;
  logic [BW-1:0]      w_adj;

  // Add-3 correction of every nibble that is 5 or more.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                 : r_bcd[4*i +: 4];
    end
  end

  // Load on start, then shift the corrected BCD left with the binary MSB entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_lost <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CW'(SCORE_W);
      r_lost <= 1'b0;
    end else if (r_cnt != '0) begin
      r_bcd  <= {w_adj[BW-2:0], r_bin[SCORE_W-1]};
      r_bin  <= r_bin << 1;
      r_cnt  <= r_cnt - 1'b1;
      r_lost <= r_lost | w_adj[BW-1];
    end
  end

  assign o_bcd2 = r_bcd[7:0];
  assign o_ovf  = r_lost | (|r_bcd[BW-1:8]);
  assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/score_scan_ctrl.sv
// Seven-segment score display controller: accepts both binary scores over
// valid/ready, converts them to BCD in parallel, commits four digit
// registers atomically and scans them onto the digit decoder.
module score_scan_ctrl
  import score_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  input  logic               score_valid,
  output logic               score_ready,
  output logic [1:0]         en,
  output logic [3:0]         num
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  state_t        r_state;
  state_t        w_next;
  logic          w_start;
  logic          w_commit;

  logic [7:0]    w_bcd_l;
  logic [7:0]    w_bcd_r;
  logic          w_ovf_l;
  logic          w_ovf_r;
  logic          w_done_l;
  logic          w_done_r;

  logic [3:0]    r_dig_lt;
  logic [3:0]    r_dig_lo;
  logic [3:0]    r_dig_rt;
  logic [3:0]    r_dig_ro;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_en;
  logic [3:0]    w_num;

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv_l (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (score_l),
    .o_bcd2  (w_bcd_l),
    .o_ovf   (w_ovf_l),
    .o_done  (w_done_l)
  );

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv_r (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (score_r),
    .o_bcd2  (w_bcd_r),
    .o_ovf   (w_ovf_r),
    .o_done  (w_done_r)
  );

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus start/commit strobes.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (score_valid) begin
          w_start = 1'b1;
          w_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_done_l && w_done_r) w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Display digit registers, all four written on the same edge; >99 shows dashes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig_lt <= '0;
      r_dig_lo <= '0;
      r_dig_rt <= '0;
      r_dig_ro <= '0;
    end else if (w_commit) begin
      r_dig_lt <= w_ovf_l ? DIGIT_DASH : w_bcd_l[7:4];
      r_dig_lo <= w_ovf_l ? DIGIT_DASH : w_bcd_l[3:0];
      r_dig_rt <= w_ovf_r ? DIGIT_DASH : w_bcd_r[7:4];
      r_dig_ro <= w_ovf_r ? DIGIT_DASH : w_bcd_r[3:0];
    end
  end

  // Free-running refresh prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_en    <= '0;
    end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_en    <= r_en + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit value mux over registered state only.
  always_comb begin
    w_num = '0;
    case (r_en)
      DIG_R_ONES: w_num = r_dig_ro;
      DIG_R_TENS: w_num = r_dig_rt;
      DIG_L_ONES: w_num = r_dig_lo;
      DIG_L_TENS: w_num = r_dig_lt;
      default:    w_num = '0;
    endcase
  end

  assign score_ready = (r_state == ST_IDLE);
  assign en          = r_en;
  assign num         = w_num;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Testbench for score_scan_ctrl with a cycle-level behavioural model of
// the display contents, ready timing and scan position.
module tb_score_scan_ctrl;

  localparam int RD = 4;
  localparam int SW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] score_l = '0;
  logic [SW-1:0] score_r = '0;
  logic          score_valid = 1'b0;
  logic          score_ready;
  logic [1:0]    en;
  logic [3:0]    num;

  always #5 clk = ~clk;

  score_scan_ctrl #(.REFRESH_DIV(RD), .SCORE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .score_l     (score_l),
    .score_r     (score_r),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .en          (en),
    .num         (num)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_k counts non-reset edges since reset, m_rem counts edges left
  // until the pending digits land on the display.
  bit m_init = 0;
  int m_k = 0;
  int m_rem = 0;
  int m_dig[4] = '{0, 0, 0, 0};
  int m_pend[4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    int l, r;
    if (reset) begin
      m_init = 1;
      m_k    = 0;
      m_rem  = 0;
      m_dig  = '{0, 0, 0, 0};
    end else begin
      m_k++;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) m_dig = m_pend;
      end else if (score_valid) begin
        l = int'(score_l);
        r = int'(score_r);
        m_rem = SW + 1;
        m_pend[3] = (l > 99) ? 15 : l / 10;
        m_pend[2] = (l > 99) ? 15 : l % 10;
        m_pend[1] = (r > 99) ? 15 : r / 10;
        m_pend[0] = (r > 99) ? 15 : r % 10;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready", score_ready, (m_rem == 0));
      chk("en", en, (m_k / RD) % 4);
      chk("num", num, m_dig[(m_k / RD) % 4]);
    end
  end

  task automatic send(input int l, input int r, input bit drop);
    bit ok;
    ok = 0;
    score_l = SW'(l);
    score_r = SW'(r);
    score_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (score_ready) begin ok = 1; break; end
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    if (drop) score_valid = 1'b0;
  endtask

  task automatic lit_digit(input string nm, input int d, input int exp);
    bit hit;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (int'(en) == d) begin hit = 1; break; end
    end
    chk("lit_en_reach", hit, 1);
    chk(nm, num, exp);
  endtask

  initial begin
    int busy, en_before, nxt;
    int lit[4];

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and scan stepping 0,1,2,3,0 every RD cycles.
    @(negedge clk);
    chk("lit_rst_ready", score_ready, 1);
    chk("lit_rst_num", num, 0);
    for (int j = 0; j < 5; j++) begin
      chk("lit_en_step", en, j % 4);
      if (j < 4) repeat (RD) @(negedge clk);
    end

    // 7 / 42: ready low for 8 cycles, then digits 2,4,7,0.
    @(posedge clk); #1;
    send(7, 42, 1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (score_ready) break;
      busy++;
    end
    chk("lit_busy_len", busy, SW + 1);
    lit_digit("lit_42_ones", 0, 2);
    lit_digit("lit_42_tens", 1, 4);
    lit_digit("lit_7_ones", 2, 7);
    lit_digit("lit_7_tens", 3, 0);

    // Over-range left, 99 right.
    @(posedge clk); #1;
    send(120, 99, 1);
    repeat (10) @(posedge clk);
    lit_digit("lit_dash_tens", 3, 15);
    lit_digit("lit_dash_ones", 2, 15);
    lit_digit("lit_99_tens", 1, 9);
    lit_digit("lit_99_ones", 0, 9);

    // Valid held through a conversion with changed data.
    @(posedge clk); #1;
    send(11, 22, 0);
    send(33, 44, 1);
    repeat (10) @(posedge clk);
    lit_digit("lit_33_tens", 3, 3);
    lit_digit("lit_44_ones", 0, 4);

    // Commit aligned with a prescaler terminal count.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ((m_k % RD) == RD - 1 && score_ready) break;
    end
    score_l = SW'(58);
    score_r = SW'(63);
    score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
    repeat (SW) @(posedge clk);
    #1 en_before = int'(en);
    @(posedge clk); #1;
    lit = '{3, 6, 8, 5};
    nxt = (en_before + 1) % 4;
    chk("lit_commit_en", en, nxt);
    chk("lit_commit_num", num, lit[nxt]);

    // Reset three cycles into SHIFT of 55 aborts the conversion.
    send(55, 0, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("lit_abort_ready", score_ready, 1);
    chk("lit_abort_en", en, 0);
    chk("lit_abort_num", num, 0);
    repeat (12) @(posedge clk);
    lit_digit("lit_abort_l_tens", 3, 0);
    lit_digit("lit_abort_l_ones", 2, 0);

    // Handshake coinciding with reset is dropped.
    @(posedge clk); #1;
    reset = 1'b1;
    score_l = SW'(77);
    score_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    score_valid = 1'b0;
    repeat (12) @(posedge clk);
    lit_digit("lit_rstvalid_tens", 3, 0);

    // Randomized traffic, including valid while busy and occasional reset.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      score_valid = ($urandom_range(0, 2) == 0);
      score_l = SW'($urandom_range(0, 127));
      score_r = SW'($urandom_range(0, 127));
      reset = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    score_valid = 1'b0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
